ifu_fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the architectural PC and drives the instruction-memory word address. It produces PC+4 as the "order" input to the next-PC selector, and latches the fetched instruction into the IF/ID pipeline register. It consumes the selector's next_pc every non-stalled cycle, detects bad fetch addresses, and keeps a fetch counter for debug.

---
 rtl/ifu_fetch_stage_pkg.sv | 17 +
 rtl/ifu_fetch_stage_if_id_reg.sv | 28 ++
 rtl/ifu_fetch_stage.sv | 80 ++++++++
 3 files changed

// File: rtl/ifu_fetch_stage_pkg.sv
// Shared pipeline definitions: reset/base addresses, NOP encoding and the IF/ID bundle.
package ifu_fetch_stage_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IFU_IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        fetch_err;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/ifu_fetch_stage_if_id_reg.sv
// Stall-gated pipeline register with asynchronous clear; sized for the IF/ID bundle by default.
module if_id_reg
  import ifu_fetch_stage_pkg::*;
#(
  parameter int W = IF_ID_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] bundle_q;
  logic [W-1:0] bundle_d;

  always_comb begin
    bundle_d = stall ? bundle_q : d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bundle_q <= '0;
    else       bundle_q <= bundle_d;
  end

  assign q_out = bundle_q;

endmodule

// File: rtl/ifu_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, fetch-address check, PC+4 and the IF/ID register.
module ifu_fetch_stage
  import ifu_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] IM_BASE  = IFU_IM_BASE,
  parameter int          IM_WORDS = 4096,
  parameter int          ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       next_pc,
  input  logic              stall,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_rdata,
  output logic [31:0]       F_pc,
  output logic [31:0]       F_pc4,
  output logic [31:0]       D_instr,
  output logic [31:0]       D_pc,
  output logic [31:0]       D_pc8,
  output logic              D_valid,
  output logic              D_fetch_err,
  output logic [31:0]       fetch_count
);

  // One past the last byte of instruction memory, kept at 33 bits so it cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

  logic [31:0]        pc_q;
  logic [31:0]        pc_d;
  logic [31:0]        fetch_count_q;
  logic [31:0]        fetch_count_d;
  logic [31:0]        pc_off;
  logic               bad;
  if_id_t             if_id_d;
  if_id_t             if_id_q;
  logic [IF_ID_W-1:0] if_id_raw_q;

  always_comb begin
    pc_off        = pc_q - IM_BASE;
    bad           = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_END);
    if_id_d           = '0;
    if_id_d.instr     = bad ? NOP_INSTR : im_rdata;
    if_id_d.pc        = pc_q;
    if_id_d.valid     = 1'b1;
    if_id_d.fetch_err = bad;
    pc_d          = stall ? pc_q : next_pc;
    fetch_count_d = stall ? fetch_count_q : fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(.W(IF_ID_W)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .d_in  (if_id_d),
    .q_out (if_id_raw_q)
  );

  assign if_id_q     = if_id_raw_q;
  assign im_addr     = ADDR_W'(pc_off >> 2);
  assign F_pc        = pc_q;
  assign F_pc4       = pc_q + 32'd4;
  assign D_instr     = if_id_q.instr;
  assign D_pc        = if_id_q.pc;
  assign D_pc8       = if_id_q.pc + 32'd8;
  assign D_valid     = if_id_q.valid;
  assign D_fetch_err = if_id_q.fetch_err;
  assign fetch_count = fetch_count_q;

endmodule
